div_controller: RTL and testbench
=================================

# div_controller

Sequencing controller for the 32-step non-restoring division datapath in the multdiv unit. It accepts a signed 32-bit divide request, converts the operands to magnitudes, and runs the non-restoring step once per clock for 32 iterations. It then corrects the remainder and applies signs, and returns quotient, remainder and a divide-by-zero exception with a one-cycle ready pulse. It sits between the multdiv top-level handshake and the per-step divider logic.

## Interface
- Parameters:
- `WIDTH`, default 32, operand/quotient width (only 32 is verified)
- `CNT_W`, default 6, iteration counter width (must hold `WIDTH`)
- Ports:
- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `ctrl_DIV`  in  1  start pulse; sampled only in IDLE
- `data_operandA`  in  32  dividend, two's complement
- `data_operandB`  in  32  divisor, two's complement
- `data_quotient`  out  32  signed quotient, truncated toward zero
- `data_remainder`  out  32  signed remainder, sign of dividend
- `data_exception`  out  1  divide by zero; valid while `data_resultRDY` is high
- `data_resultRDY`  out  1  one-cycle pulse, result valid
- `busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, ITER, FIX, DONE.
- IDLE, `ctrl_DIV`=1:
  - Latch A and B.
  - Compute `q_neg` = A[31]^B[31] and `r_neg` = A[31].
  - If B==0, go to DONE with exception set. Otherwise go to LOAD.
- LOAD:
  - Working state = {33'b0 remainder, |A| quotient}.
  - Divisor register = {1'b0, |B|} (33 bits). |-2^31| = 0x80000000 unsigned.
  - Counter = 0.
- ITER:
  - Each cycle, shift {rem,quo} left by one.
  - If the old rem sign bit (bit 32) is 1, add the divisor to rem; otherwise subtract it.
  - quo[0] = ~new_rem[32].
  - Counter increments. After the 32nd step, go to FIX.
- FIX:
  - If rem[32]==1, rem += divisor.
  - Quotient = `q_neg` ? -quo : quo.
  - Remainder = `r_neg` ? -rem[31:0] : rem[31:0].
  - Go to DONE.
- DONE:
  - `data_resultRDY`=1 for one cycle.
  - Outputs hold their values until the next start completes.
  - Go to IDLE.
- Arithmetic: the remainder path is 33 bits, the quotient path 32 bits, and negation wraps modulo 2^32.
- Overflow: -2^31 / -1 gives quotient 0x80000000, remainder 0, and no exception.
- Divide by zero: quotient 0, remainder 0, `data_exception`=1.
- `ctrl_DIV` while busy is ignored; the operands are not re-sampled.
- `ctrl_DIV` held high across DONE→IDLE starts a new operation on the first IDLE cycle.
- Reset mid-operation aborts immediately. There is no partial result and no ready pulse.

## Timing
- Reset values:
  - state = IDLE
  - `data_quotient`=0, `data_remainder`=0
  - `data_exception`=0, `data_resultRDY`=0, `busy`=0
  - counter = 0
- Edge numbering: the start is sampled at edge E0.
- Normal division:
  - E0 → LOAD
  - E1 → ITER
  - E2–E33: 32 steps
  - E34 → FIX done, DONE entered
  - `data_resultRDY` is high during the cycle after E34, so the latency is 35 cycles including the start edge.
- Divide by zero: DONE is entered at E0 and `data_resultRDY` is high in the cycle after E0.
- Back-to-back: the minimum start-to-start spacing is 36 cycles (normal) and 2 cycles (exception).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared multdiv package contains:
  - state enum `div_state_t`
  - `DIV_STEPS`=32
  - `DIV_REM_W`=33
- Sub-module `div_nonres_step`: combinational single non-restoring step.
  - Inputs: 65-bit {rem,quo} and 33-bit divisor.
  - Output: next 65-bit {rem,quo}.
  - Instantiated once inside `div_controller`.
  - Verified standalone against a reference step model.
- The controller holds the FSM, counter, operand/sign registers and the FIX logic.

## Test plan
- 100 / 7 → quotient 14, remainder 2, no exception; ready exactly 35 cycles after start.
- -100 / 7 → quotient -14, remainder -2. 100 / -7 → quotient -14, remainder 2.
- 5 / 0 → quotient 0, remainder 0, exception 1; ready one cycle after start.
- -2147483648 / -1 → quotient 0x80000000, remainder 0, no exception. 0x7FFFFFFF / 1 → quotient 0x7FFFFFFF.
- Pulse `ctrl_DIV` with 9/2 at cycle 10 of a running 100/7 → the running result is unchanged (14, 2) and only one ready pulse occurs.
- Assert `reset_n` low at iteration 16, then release and start 81/9 → after the abort, all outputs are 0 and `busy` is 0; the new result is 9, 0 with one ready pulse.

Source files
------------

// File: rtl/div_controller_pkg.sv
// Shared multdiv definitions: divider FSM states and datapath constants.
package div_controller_pkg;

  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned DIV_REM_W = 33;

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_LOAD,
    DIV_ITER,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/div_nonres_step.sv
// One combinational non-restoring division step on the packed {rem, quo} word.
module div_nonres_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH:0]   divisor_i,
  output logic [2*WIDTH:0] acc_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] rem_nx;

  always_comb begin
    // Shift {rem,quo} left by one; the add/sub choice uses the sign before the shift.
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    if (acc_i[2*WIDTH]) begin
      rem_nx = rem_sh + divisor_i;
    end else begin
      rem_nx = rem_sh - divisor_i;
    end
    acc_o = {rem_nx, acc_i[WIDTH-2:0], ~rem_nx[WIDTH]};
  end

endmodule

// File: rtl/div_controller.sv
// Signed 32-step non-restoring divide sequencer with registered result and ready pulse.
module div_controller
  import div_controller_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_quotient,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH:0] acc_q, acc_d, acc_step;
  logic [WIDTH:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;

  logic [WIDTH-1:0] a_abs, b_abs, rem_fix;

  div_nonres_step #(.WIDTH(WIDTH)) u_step (
    .acc_i     (acc_q),
    .divisor_i (divisor_q),
    .acc_o     (acc_step)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    a_d       = a_q;
    b_d       = b_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;

    a_abs   = a_q[WIDTH-1] ? -a_q : a_q;
    b_abs   = b_q[WIDTH-1] ? -b_q : b_q;
    // Low bits of the corrected 33-bit remainder; bit 32 is always 0 after the fix.
    rem_fix = acc_q[2*WIDTH-1:WIDTH] + (acc_q[2*WIDTH] ? divisor_q[WIDTH-1:0] : '0);

    unique case (state_q)
      DIV_IDLE: begin
        if (ctrl_DIV) begin
          a_d     = data_operandA;
          b_d     = data_operandB;
          q_neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          r_neg_d = data_operandA[WIDTH-1];
          if (data_operandB == '0) begin
            quo_d   = '0;
            rem_d   = '0;
            exc_d   = 1'b1;
            rdy_d   = 1'b1;
            state_d = DIV_DONE;
          end else begin
            state_d = DIV_LOAD;
          end
        end
      end
      DIV_LOAD: begin
        acc_d     = {{(WIDTH+1){1'b0}}, a_abs};
        divisor_d = {1'b0, b_abs};
        cnt_d     = '0;
        state_d   = DIV_ITER;
      end
      DIV_ITER: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        quo_d   = q_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_d   = r_neg_q ? -rem_fix : rem_fix;
        exc_d   = 1'b0;
        rdy_d   = 1'b1;
        state_d = DIV_DONE;
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    busy_d = (state_d != DIV_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      divisor_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      a_q       <= a_d;
      b_q       <= b_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign data_quotient  = quo_q;
  assign data_remainder = rem_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_div_controller.sv
// Directed bench for div_controller: signed results, latency, busy-ignore, held start, reset abort.
module tb_div_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_quotient;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int n_rdy = 0;
  int lat;
  int snap;

  div_controller #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_quotient  (data_quotient),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (data_resultRDY === 1'b1) n_rdy <= n_rdy + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      $error("%s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Presents a start at a negedge; returns just after the sampling edge E0.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    t0            = cyc;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0BAD_F00D;
  endtask

  // Latency in cycles counted with the start edge as cycle 1; -1 on timeout.
  task automatic wait_rdy(output int l);
    l = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        l = cyc - t0 + 1;
        break;
      end
    end
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ee,
                        input int elat);
    start(a, b);
    wait_rdy(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_quo"}, data_quotient, eq);
    chk({tag, "_rem"}, data_remainder, er);
    chk({tag, "_exc"}, 32'(data_exception), 32'(ee));
    @(negedge clock);
    chk({tag, "_rdy_low"}, 32'(data_resultRDY), 32'd0);
    chk({tag, "_quo_hold"}, data_quotient, eq);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_quo", data_quotient, 32'd0);
    chk("rst_rem", data_remainder, 32'd0);
    chk("rst_exc", 32'(data_exception), 32'd0);
    chk("rst_rdy", 32'(data_resultRDY), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    do_div("p100_7",   32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 35);
    do_div("n100_7",   32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 35);
    do_div("p100_n7",  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 35);
    do_div("div0",     32'd5,          32'd0,          32'd0,          32'd0,          1'b1, 1);
    do_div("ovf",      32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 35);
    do_div("max_1",    32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0, 35);
    chk("idle_busy", 32'(busy), 32'd0);

    // Start pulse while busy must be ignored.
    snap = n_rdy;
    start(32'd100, 32'd7);
    chk("run_busy", 32'(busy), 32'd1);
    repeat (9) @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd9; data_operandB = 32'd2;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_rdy(lat);
    chk("ign_lat", 32'(lat), 32'd35);
    chk("ign_quo", data_quotient, 32'd14);
    chk("ign_rem", data_remainder, 32'd2);
    repeat (40) @(negedge clock);
    chk("ign_pulses", 32'(n_rdy - snap), 32'd1);

    // Start held high with a zero divisor restarts every two cycles.
    snap = n_rdy;
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd3; data_operandB = 32'd0;
    repeat (4) @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (3) @(negedge clock);
    chk("held_pulses", 32'(n_rdy - snap), 32'd2);

    // Reset mid-iteration aborts with no ready pulse.
    do_div("pre_abort", 32'd50, 32'd7, 32'd7, 32'd1, 1'b0, 35);
    snap = n_rdy;
    start(32'd100, 32'd7);
    repeat (17) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_quo", data_quotient, 32'd0);
    chk("abort_rem", data_remainder, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("abort_pulses", 32'(n_rdy - snap), 32'd0);
    snap = n_rdy;
    do_div("p81_9", 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 35);
    repeat (5) @(negedge clock);
    chk("p81_pulses", 32'(n_rdy - snap), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
